// File: rtl/clk_step_ctrl.sv
// Debug step controller: turns run/halt/step commands into stop targets for
// clk_count_stop and tracks the number of gated cycles since reset.
module clk_step_ctrl #(
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned STEP_W = 32
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              match,
  output logic              active,
  output logic [CNT_W-1:0]  trg_count,
  output logic [CNT_W-1:0]  cyc_count,
  output logic              halted,
  output logic              step_done
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STEPPING,
    ST_HALTING,
    ST_HALTED
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_RUN  = 2'b01,
    OP_STEP = 2'b10,
    OP_HALT = 2'b11
  } op_t;

  state_t             state_q, state_d;
  logic               active_q, active_d;
  logic [CNT_W-1:0]   trg_q, trg_d;
  logic [CNT_W-1:0]   cyc_q;
  logic               halted_q;
  logic               done_q, done_d;
  logic               accept;
  logic               gen;
  logic               steps_nz;
  logic [CNT_W-1:0]   steps_ext;

  assign gen       = !(active_q && match);
  assign cmd_ready = (state_q == ST_RUN) || (state_q == ST_HALTED);
  assign accept    = cmd_valid && cmd_ready;
  assign steps_nz  = (cmd_steps != '0);
  assign steps_ext = CNT_W'(cmd_steps);

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    trg_d    = trg_q;
    done_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (cmd_op == OP_STEP && steps_nz) begin
            trg_d    = cyc_q + steps_ext;
            active_d = 1'b1;
            state_d  = ST_STEPPING;
          end else if (cmd_op == OP_HALT || cmd_op == OP_STEP) begin
            // A zero-length step from RUN behaves as HALT.
            trg_d    = cyc_q + CNT_W'(1);
            active_d = 1'b1;
            state_d  = ST_HALTING;
          end
        end
      end
      ST_STEPPING, ST_HALTING: begin
        if (match) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end
      end
      ST_HALTED: begin
        if (accept) begin
          if (cmd_op == OP_STEP) begin
            if (steps_nz) begin
              // Stopped at target, so trg_q equals the cycle count here.
              trg_d   = trg_q + steps_ext;
              state_d = ST_STEPPING;
            end else begin
              done_d = 1'b1;
            end
          end else if (cmd_op == OP_RUN) begin
            active_d = 1'b0;
            state_d  = ST_RUN;
          end
        end
      end
      default: begin
        state_d  = ST_RUN;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      active_q <= 1'b0;
      trg_q    <= '0;
      cyc_q    <= '0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      trg_q    <= trg_d;
      halted_q <= (state_d == ST_HALTED);
      done_q   <= done_d;
      if (gen) begin
        cyc_q <= cyc_q + CNT_W'(1);
      end
    end
  end

  assign active    = active_q;
  assign trg_count = trg_q;
  assign cyc_count = cyc_q;
  assign halted    = halted_q;
  assign step_done = done_q;

endmodule
